// File: rtl/sp_float_pkg.sv
// Shared single-precision float definitions: field positions, special values and
// the sequencer state encoding used by the float family.
package sp_float_pkg;

   localparam int SIGN    = 31;
   localparam int EXP_HI  = 30;
   localparam int EXP_LO  = 23;
   localparam int MANT_HI = 22;
   localparam int MANT_LO = 0;

   localparam logic [31:0] SP_ZERO = 32'h0000_0000;
   localparam logic [31:0] SP_NAN  = 32'hFFFF_FFFF;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      ROUND,
      DONE
   } state_t;

endpackage

// File: rtl/sp_align_shift.sv
// 24-bit mantissa right barrel shifter producing guard, round and sticky bits
// from the bits shifted out below the mantissa.
module sp_align_shift (
   input  logic [23:0] i_mant,
   input  logic [7:0]  i_shift,
   output logic [23:0] o_mant,
   output logic        o_guard,
   output logic        o_round,
   output logic        o_sticky
);

   logic [25:0] w_ext;
   logic [7:0]  w_stickyShift;
   logic [23:0] w_lostMask;

   assign w_ext    = {i_mant, 2'b00} >> i_shift;
   assign o_mant   = w_ext[25:2];
   assign o_guard  = w_ext[1];
   assign o_round  = w_ext[0];

   // Sticky collects every mantissa bit that lands below the round position.
   assign w_stickyShift = (i_shift < 8'd2) ? 8'd0 : i_shift - 8'd2;
   assign w_lostMask    = ~({24{1'b1}} << w_stickyShift);
   assign o_sticky      = |(i_mant & w_lostMask);

endmodule

// File: rtl/sradd_seq.sv
// Multi-cycle single-precision adder with valid/ready handshakes.
// Define SRADD_SEQ_ROUND_EN to add a round-to-nearest-even stage; default truncates.
module sradd_seq
   import sp_float_pkg::*;
#(
   parameter logic [31:0] NAN_VAL  = SP_NAN,
   parameter int          MAX_NORM = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] z
);

`ifdef SRADD_SEQ_ROUND_EN
   localparam logic   ROUND_EN  = 1'b1;
   localparam state_t PACK_NEXT = ROUND;
`else
   localparam logic   ROUND_EN  = 1'b0;
   localparam state_t PACK_NEXT = DONE;
`endif

   localparam logic [5:0] MAX_NORM_C = 6'(MAX_NORM);

   state_t      r_state, w_next;
   logic [31:0] r_a, r_b, r_z;
   logic [26:0] r_mL, r_mS;
   logic [27:0] r_m;
   logic [7:0]  r_e;
   logic        r_sign, r_effSub;
   logic [5:0]  r_cnt;

   logic        w_aBig;
   logic [31:0] w_big;
   logic [30:0] w_small;
   logic [7:0]  w_ediff;
   logic [23:0] w_shMant;
   logic        w_g, w_r, w_s;
   logic        w_special;
   logic [31:0] w_specialZ;
   logic [27:0] w_sum;

   logic [27:0] w_stepIn, w_stepM;
   logic [7:0]  w_stepE;
   logic [5:0]  w_stepCnt;
   logic        w_stepDone, w_stepPack;
   logic [31:0] w_stepZ;

   assign w_aBig  = r_a[EXP_HI:MANT_LO] >= r_b[EXP_HI:MANT_LO];
   assign w_big   = w_aBig ? r_a : r_b;
   assign w_small = w_aBig ? r_b[EXP_HI:MANT_LO] : r_a[EXP_HI:MANT_LO];
   assign w_ediff = w_big[EXP_HI:EXP_LO] - w_small[EXP_HI:EXP_LO];

   sp_align_shift u_align (
      .i_mant   ({1'b1, w_small[MANT_HI:MANT_LO]}),
      .i_shift  (w_ediff),
      .o_mant   (w_shMant),
      .o_guard  (w_g),
      .o_round  (w_r),
      .o_sticky (w_s)
   );

   always_comb begin
      w_special  = 1'b1;
      w_specialZ = SP_ZERO;
      if (r_a[EXP_HI:EXP_LO] == EXP_MAX || r_b[EXP_HI:EXP_LO] == EXP_MAX)
         w_specialZ = NAN_VAL;
      else if (r_a[EXP_HI:EXP_LO] == 8'd0)
         w_specialZ = (r_b[EXP_HI:EXP_LO] == 8'd0) ? SP_ZERO : r_b;
      else if (r_b[EXP_HI:EXP_LO] == 8'd0)
         w_specialZ = r_a;
      else
         w_special = 1'b0;
   end

   // Mantissa layout: [27] carry, [26:3] 1.f, [2:0] guard/round/sticky.
   assign w_sum = r_effSub ? ({1'b0, r_mL} - {1'b0, r_mS})
                           : ({1'b0, r_mL} + {1'b0, r_mS});

   // One normalization action per cycle; ADD applies the first action to the fresh sum.
   always_comb begin
      w_stepIn   = (r_state == ADD) ? w_sum : r_m;
      w_stepM    = w_stepIn;
      w_stepE    = r_e;
      w_stepCnt  = r_cnt;
      w_stepDone = 1'b0;
      w_stepPack = 1'b0;
      w_stepZ    = SP_ZERO;
      if (w_stepIn == '0) begin
         w_stepDone = 1'b1;
      end else if (w_stepIn[27]) begin
         w_stepM = {1'b0, w_stepIn[27:2], w_stepIn[1] | w_stepIn[0]};
         w_stepE = r_e + 8'd1;
         if (r_e == 8'hFE) begin
            w_stepDone = 1'b1;
            w_stepZ    = NAN_VAL;
         end
      end else if (w_stepIn[26]) begin
         w_stepPack = 1'b1;
         w_stepZ    = {r_sign, r_e, w_stepIn[25:3]};
      end else begin
         w_stepM   = {w_stepIn[26:0], 1'b0};
         w_stepE   = r_e - 8'd1;
         w_stepCnt = r_cnt + 6'd1;
         if (w_stepE == 8'd0 || w_stepCnt > MAX_NORM_C)
            w_stepDone = 1'b1;
      end
   end

`ifdef SRADD_SEQ_ROUND_EN
   logic        w_rndUp;
   logic [24:0] w_rndM;
   logic [31:0] w_rndZ;

   always_comb begin
      w_rndUp = r_m[2] & (r_m[1] | r_m[0] | r_m[3]);
      w_rndM  = {1'b0, r_m[26:3]} + {24'd0, w_rndUp};
      w_rndZ  = {r_sign, r_e, w_rndM[22:0]};
      if (w_rndM[24]) begin
         if (r_e == 8'hFE)
            w_rndZ = NAN_VAL;
         else
            w_rndZ = {r_sign, r_e + 8'd1, w_rndM[23:1]};
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      case (r_state)
         IDLE:      if (in_valid) w_next = ALIGN;
         ALIGN:     w_next = w_special ? DONE : ADD;
         ADD, NORM: begin
            if (w_stepDone)
               w_next = DONE;
            else if (w_stepPack)
               w_next = PACK_NEXT;
            else
               w_next = NORM;
         end
         ROUND:     w_next = DONE;
         DONE:      if (out_ready) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   assign z = r_z;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_z      <= SP_ZERO;
         r_mL     <= '0;
         r_mS     <= '0;
         r_m      <= '0;
         r_e      <= '0;
         r_sign   <= 1'b0;
         r_effSub <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a <= a;
                  r_b <= b;
               end
            end
            ALIGN: begin
               if (w_special)
                  r_z <= w_specialZ;
               r_e      <= w_big[EXP_HI:EXP_LO];
               r_sign   <= w_big[SIGN];
               r_effSub <= r_a[SIGN] ^ r_b[SIGN];
               r_cnt    <= '0;
               r_mL     <= {1'b1, w_big[MANT_HI:MANT_LO], 3'b000};
               r_mS     <= {w_shMant, {w_g, w_r, w_s} & {3{ROUND_EN}}};
            end
            ADD, NORM: begin
               r_m   <= w_stepM;
               r_e   <= w_stepE;
               r_cnt <= w_stepCnt;
               if (w_stepDone || (w_stepPack && !ROUND_EN))
                  r_z <= w_stepZ;
            end
`ifdef SRADD_SEQ_ROUND_EN
            ROUND: r_z <= w_rndZ;
`endif
            default: ;
         endcase
      end
   end

endmodule
